// File: rtl/sha_msg_scheduler_p.sv
// SHA-2 message-schedule generator (SHA-256 or SHA-512, chosen by ALG).
//
// Accepts one padded 16-word message block and streams the ROUNDS schedule
// words W[0..ROUNDS-1] over a valid/ready interface, one word per cycle when
// the consumer never stalls. A 16-word sliding window holds W[t..t+15];
// every accepted word shifts the window and appends W[t+16].
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   abort      synchronous flush back to IDLE (wins over every handshake)
//   blk_valid  a padded block is offered on blk_data
//   blk_ready  the scheduler accepts the offered block this cycle
//   blk_data   BLOCK_W-bit message block, word 0 in the MSBs
//   w_valid    a schedule word is presented
//   w_ready    the consumer takes the presented word
//   w_data     schedule word W[w_idx]
//   w_idx      round index of w_data
//   w_last     w_idx is the final round (ROUNDS-1)
//   busy       the scheduler is streaming a block
module sha_msg_scheduler_p #(
    parameter  int ALG     = 256,
    localparam int WORD_W  = (ALG == 512) ? 64 : 32,
    localparam int ROUNDS  = (ALG == 512) ? 80 : 64,
    localparam int BLOCK_W = 16 * WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WORD_W-1:0]  w_data,
    output logic [6:0]         w_idx,
    output logic               w_last,
    output logic               busy
);

    if (ALG != 256 && ALG != 512) begin : g_bad_alg
        $error("sha_msg_scheduler_p: ALG must be 256 or 512");
    end

    // Small-sigma rotate/shift amounts for the selected algorithm.
    localparam int S0_R1 = (ALG == 512) ? 1  : 7;
    localparam int S0_R2 = (ALG == 512) ? 8  : 18;
    localparam int S0_SH = (ALG == 512) ? 7  : 3;
    localparam int S1_R1 = (ALG == 512) ? 19 : 17;
    localparam int S1_R2 = (ALG == 512) ? 61 : 19;
    localparam int S1_SH = (ALG == 512) ? 6  : 10;

    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] w_next;
    logic              accept;
    logic              w_take;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    // W[t+16] from the current window (win[0] = W[t]); wraps mod 2^WORD_W.
    assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    assign w_last = (state == RUN) && (w_idx == LAST_IDX);
    assign w_data = win[0];
    assign accept = blk_valid && blk_ready;
    // abort cancels the word handshake as well as block acceptance.
    assign w_take = w_valid && w_ready && !abort;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = RUN;
        end else if (w_take && w_last) begin
            state_next = IDLE;
        end
    end

    // Output logic. blk_ready in RUN only opens on the final word so a new
    // block follows the last word with no bubble; abort closes it.
    always_comb begin
        w_valid   = 1'b0;
        busy      = 1'b0;
        blk_ready = 1'b0;
        case (state)
            IDLE: blk_ready = !abort;
            RUN: begin
                w_valid   = 1'b1;
                busy      = 1'b1;
                blk_ready = !abort && w_last && w_ready;
            end
            default: ;
        endcase
    end

    // Window and round index.
    // NOTE: the window is reset (not left uninitialised like a RAM) because
    // w_data reads win[0] directly and must be zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                win[k] <= '0;
            end
            w_idx <= '0;
        end else if (abort) begin
            w_idx <= '0;
        end else if (accept) begin
            for (int k = 0; k < 16; k++) begin
                win[k] <= blk_data[BLOCK_W-1-k*WORD_W -: WORD_W];
            end
            w_idx <= '0;
        end else if (w_take) begin
            if (w_last) begin
                w_idx <= '0;
            end else begin
                for (int k = 0; k < 15; k++) begin
                    win[k] <= win[k+1];
                end
                win[15] <= w_next;
                w_idx   <= w_idx + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha_msg_scheduler_p.sv
// Self-checking bench for sha_msg_scheduler_p: a SHA-256 and a SHA-512
// instance share clock and reset. Each accepted block pushes its reference
// schedule onto a per-instance queue; each word handshake pops and compares.
module tb_sha_msg_scheduler_p;

    typedef struct packed {
        logic [63:0] d;
        logic [6:0]  idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // SHA-256 instance
    logic         d_abort, d_blk_valid, d_blk_ready, d_w_valid, d_w_ready, d_w_last, d_busy;
    logic [511:0] d_blk_data;
    logic [31:0]  d_w_data;
    logic [6:0]   d_w_idx;

    // SHA-512 instance
    logic          e_abort, e_blk_valid, e_blk_ready, e_w_valid, e_w_ready, e_w_last, e_busy;
    logic [1023:0] e_blk_data;
    logic [63:0]   e_w_data;
    logic [6:0]    e_w_idx;

    sha_msg_scheduler_p #(.ALG(256)) u_d (
        .clk(clk), .rst_n(rst_n), .abort(d_abort),
        .blk_valid(d_blk_valid), .blk_ready(d_blk_ready), .blk_data(d_blk_data),
        .w_valid(d_w_valid), .w_ready(d_w_ready), .w_data(d_w_data),
        .w_idx(d_w_idx), .w_last(d_w_last), .busy(d_busy)
    );

    sha_msg_scheduler_p #(.ALG(512)) u_e (
        .clk(clk), .rst_n(rst_n), .abort(e_abort),
        .blk_valid(e_blk_valid), .blk_ready(e_blk_ready), .blk_data(e_blk_data),
        .w_valid(e_w_valid), .w_ready(e_w_ready), .w_data(e_w_data),
        .w_idx(e_w_idx), .w_last(e_w_last), .busy(e_busy)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        q256[$];
    exp_t        q512[$];
    logic [63:0] blk256 [16];
    logic [63:0] blk512 [16];
    logic [63:0] ref_w [80];
    logic        chk_abc256 = 1'b0;
    logic        chk_abc512 = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic [6:0]  prev_idx;
    logic        b2b_pending = 1'b0;
    logic        acc256 = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (standard W[t] recurrence) ----------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        if (w == 32) return {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] m_s0(input logic [63:0] x, input int alg);
        if (alg == 256) return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
        return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] m_s1(input logic [63:0] x, input int alg);
        if (alg == 256) return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
        return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    endfunction

    task automatic push_sched(input int alg);
        int          rounds;
        logic [63:0] sum;
        exp_t        e;
        rounds = (alg == 256) ? 64 : 80;
        for (int t = 0; t < rounds; t++) begin
            if (t < 16) begin
                ref_w[t] = (alg == 256) ? blk256[t] : blk512[t];
            end else begin
                sum = m_s1(ref_w[t-2], alg) + ref_w[t-7] + m_s0(ref_w[t-15], alg) + ref_w[t-16];
                ref_w[t] = (alg == 256) ? {32'h0, sum[31:0]} : sum;
            end
            e.d    = ref_w[t];
            e.idx  = 7'(t);
            e.last = (t == rounds - 1);
            if (alg == 256) q256.push_back(e);
            else            q512.push_back(e);
        end
    endtask

    function automatic logic [511:0] pack256();
        logic [511:0] p;
        for (int k = 0; k < 16; k++) p[511-k*32 -: 32] = blk256[k][31:0];
        return p;
    endfunction

    function automatic logic [1023:0] pack512();
        logic [1023:0] p;
        for (int k = 0; k < 16; k++) p[1023-k*64 -: 64] = blk512[k];
        return p;
    endfunction

    task automatic load_abc256();
        for (int k = 0; k < 16; k++) blk256[k] = '0;
        blk256[0]  = 64'h61626380;
        blk256[15] = 64'h18;
        d_blk_data = pack256();
    endtask

    task automatic load_rand256();
        for (int k = 0; k < 16; k++) blk256[k] = {32'h0, $urandom()};
        d_blk_data = pack256();
    endtask

    // ---------------- one clock cycle: sample mid-cycle, then advance -----
    // Called at posedge+1 with this cycle's inputs already driven.
    task automatic tick();
        exp_t e;
        #4;
        acc256 = 1'b0;
        if (b2b_pending) begin
            check("b2b_no_gap_valid", 64'(d_w_valid), 64'd1);
            check("b2b_next_idx0", 64'(d_w_idx), 64'd0);
            b2b_pending = 1'b0;
        end
        if (stall_prev && d_w_valid) begin
            check("stall_data", 64'(d_w_data), 64'(prev_data));
            check("stall_idx", 64'(d_w_idx), 64'(prev_idx));
        end
        if (d_w_valid && d_w_ready) begin
            check("sb256_nonempty", 64'(q256.size() > 0), 64'd1);
            if (q256.size() > 0) begin
                e = q256.pop_front();
                check("w256_data", 64'(d_w_data), e.d);
                check("w256_idx", 64'(d_w_idx), 64'(e.idx));
                check("w256_last", 64'(d_w_last), 64'(e.last));
                if (chk_abc256 && d_w_idx == 7'd16) check("abc256_w16", 64'(d_w_data), 64'h61626380);
                if (chk_abc256 && d_w_idx == 7'd17) check("abc256_w17", 64'(d_w_data), 64'h000F0000);
            end
        end
        stall_prev = d_w_valid && !d_w_ready;
        prev_data  = d_w_data;
        prev_idx   = d_w_idx;
        if (d_blk_valid && d_blk_ready) begin
            if (d_w_valid && d_w_ready && d_w_last) b2b_pending = 1'b1;
            push_sched(256);
            acc256 = 1'b1;
        end
        if (e_w_valid && e_w_ready) begin
            check("sb512_nonempty", 64'(q512.size() > 0), 64'd1);
            if (q512.size() > 0) begin
                e = q512.pop_front();
                check("w512_data", e_w_data, e.d);
                check("w512_idx", 64'(e_w_idx), 64'(e.idx));
                check("w512_last", 64'(e_w_last), 64'(e.last));
                if (chk_abc512 && e_w_idx == 7'd16) check("abc512_w16", e_w_data, 64'h6162638000000000);
                if (chk_abc512 && e_w_idx == 7'd17) check("abc512_w17", e_w_data, 64'h00030000000000C0);
            end
        end
        if (e_blk_valid && e_blk_ready) push_sched(512);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((q256.size() > 0 || q512.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(q256.size() + q512.size()), 64'd0);
    endtask

    task automatic run_to_idx(input logic [6:0] target, input string tag);
        int n = 0;
        while (d_w_idx != target && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(d_w_idx), 64'(target));
    endtask

    initial begin
        rst_n       = 1'b0;
        d_abort     = 1'b0; d_blk_valid = 1'b0; d_w_ready = 1'b1; d_blk_data = '0;
        e_abort     = 1'b0; e_blk_valid = 1'b0; e_w_ready = 1'b1; e_blk_data = '0;

        // ---- reset state ----
        #2;
        check("rst_w_valid", 64'(d_w_valid), 64'd0);
        check("rst_busy", 64'(d_busy), 64'd0);
        check("rst_w_data", 64'(d_w_data), 64'd0);
        check("rst_w_idx", 64'(d_w_idx), 64'd0);
        check("rst512_w_data", e_w_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_blk_ready", 64'(d_blk_ready), 64'd1);
        check("post_rst_blk_ready512", 64'(e_blk_ready), 64'd1);

        // ---- "abc" on both algorithms, w_ready held high ----
        load_abc256();
        for (int k = 0; k < 16; k++) blk512[k] = '0;
        blk512[0]  = 64'h6162638000000000;
        blk512[15] = 64'h18;
        e_blk_data = pack512();
        chk_abc256 = 1'b1; chk_abc512 = 1'b1;
        d_blk_valid = 1'b1; e_blk_valid = 1'b1;
        tick();
        d_blk_valid = 1'b0; e_blk_valid = 1'b0;
        check("first_word_valid", 64'(d_w_valid), 64'd1);
        check("first_word_idx", 64'(d_w_idx), 64'd0);
        drain("abc_drain", 200);
        check("abc_done_valid", 64'(d_w_valid), 64'd0);
        check("abc_done_idx", 64'(d_w_idx), 64'd0);
        check("abc512_done_valid", 64'(e_w_valid), 64'd0);
        chk_abc512 = 1'b0;

        // ---- backpressure: random w_ready, same abc sequence ----
        d_blk_valid = 1'b1;
        tick();
        d_blk_valid = 1'b0;
        for (int n = 0; n < 1000 && q256.size() > 0; n++) begin
            d_w_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("bp_drain", 64'(q256.size()), 64'd0);
        d_w_ready = 1'b1;
        stall_prev = 1'b0;
        chk_abc256 = 1'b0;

        // ---- back-to-back: blk_valid held across two random blocks ----
        load_rand256();
        d_blk_valid = 1'b1;
        tick();
        load_rand256();
        for (int n = 0; n < 200; n++) begin
            tick();
            if (acc256) break;
        end
        check("b2b_second_accepted", 64'(acc256), 64'd1);
        d_blk_valid = 1'b0;
        drain("b2b_drain", 200);

        // ---- abort at idx 20 with a block offered the same cycle ----
        load_rand256();
        d_blk_valid = 1'b1;
        tick();
        d_blk_valid = 1'b0;
        run_to_idx(7'd20, "abort_reach_idx20");
        load_rand256();
        d_abort = 1'b1; d_blk_valid = 1'b1; d_w_ready = 1'b0;
        tick();
        d_abort = 1'b0; d_blk_valid = 1'b0; d_w_ready = 1'b1;
        #1;
        check("abort_w_valid", 64'(d_w_valid), 64'd0);
        check("abort_busy", 64'(d_busy), 64'd0);
        check("abort_w_idx", 64'(d_w_idx), 64'd0);
        check("abort_blk_ready", 64'(d_blk_ready), 64'd1);
        q256.delete();
        stall_prev = 1'b0;
        @(posedge clk); #1;

        // ---- asynchronous reset at idx 30, then a fresh abc block ----
        load_abc256();
        d_blk_valid = 1'b1;
        tick();
        d_blk_valid = 1'b0;
        run_to_idx(7'd30, "rst_reach_idx30");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_w_valid", 64'(d_w_valid), 64'd0);
        check("midrst_busy", 64'(d_busy), 64'd0);
        check("midrst_w_data", 64'(d_w_data), 64'd0);
        check("midrst_w_idx", 64'(d_w_idx), 64'd0);
        q256.delete();
        stall_prev = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_rst_blk_ready", 64'(d_blk_ready), 64'd1);
        chk_abc256 = 1'b1;
        d_blk_valid = 1'b1;
        tick();
        d_blk_valid = 1'b0;
        check("restart_idx0", 64'(d_w_idx), 64'd0);
        drain("restart_drain", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_msg_scheduler_p.md
SHA_MSG_SCHEDULER_P -- requirements
Module: sha_msg_scheduler_p

Interface
REQ-001 Parameter ALG, default 256, selects algorithm: 256 = SHA-256, 512 = SHA-512; any other value SHALL fail elaboration.
REQ-002 Derived constant WORD_W SHALL be 32 for ALG=256 and 64 for ALG=512.
REQ-003 Derived constant ROUNDS SHALL be 64 for ALG=256 and 80 for ALG=512.
REQ-004 Derived constant BLOCK_W SHALL equal 16*WORD_W.
REQ-005 Ports SHALL be, in order:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous reset, active-low.
abort  in  1  synchronous flush.
blk_valid  in  1  a padded block is offered.
blk_ready  out  1  the scheduler accepts a block.
blk_data  in  BLOCK_W  message block; word 0 is in the MSBs.
w_valid  out  1  a schedule word is presented.
w_ready  in  1  the consumer takes the word.
w_data  out  WORD_W  schedule word W[w_idx].
w_idx  out  7  round index of w_data.
w_last  out  1  w_idx equals ROUNDS-1.
busy  out  1  the scheduler is in RUN.
REQ-006 There SHALL be exactly one clock, clk; rst_n is asynchronous and active-low.

Function
REQ-007 The FSM SHALL have two states:
- IDLE: blk_ready=1, w_valid=0.
- RUN: w_valid=1, busy=1, blk_ready=w_last&&w_ready.
REQ-008 Block acceptance: when blk_valid&&blk_ready, the block SHALL be loaded into a 16-word window, win[k] = blk_data[BLOCK_W-1-k*WORD_W -: WORD_W].
REQ-009 On block acceptance, w_idx SHALL be set to 0 and the state SHALL become RUN.
REQ-010 w_valid SHALL rise on the clock edge after block acceptance.
REQ-011 w_data SHALL be driven directly from win[0], with no combinational path from any input.
REQ-012 On a word handshake (w_valid&&w_ready) with w_last=0:
- the window SHALL shift, win[k] <= win[k+1] for k=0..14;
- win[15] SHALL load s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^WORD_W;
- w_idx SHALL increment by 1.
REQ-013 The s0/s1 functions for ALG=256 SHALL be:
- s0 = ROTR7^ROTR18^SHR3
- s1 = ROTR17^ROTR19^SHR10
REQ-014 The s0/s1 functions for ALG=512 SHALL be:
- s0 = ROTR1^ROTR8^SHR7
- s1 = ROTR19^ROTR61^SHR6
REQ-015 While w_valid=1 and w_ready=0, w_data, w_idx and the window SHALL hold stable.
REQ-016 A handshake with w_last=1 and blk_valid=0 SHALL return the FSM to IDLE, with w_idx at 0.
REQ-017 A handshake with w_last=1 and blk_valid=1 SHALL load the new block and stay in RUN, with no bubble cycle.
REQ-018 abort=1 SHALL force IDLE and w_idx=0 on the next edge.
REQ-019 abort SHALL take priority over all handshakes; a block offered in the same cycle as abort SHALL NOT be accepted.
REQ-020 A throughput of one word per cycle SHALL be sustained while w_ready=1; one block of ROUNDS words SHALL occupy ROUNDS RUN cycles.
REQ-021 blk_valid asserted while the state is RUN and w_last=0 SHALL be ignored; the block SHALL stay pending until blk_ready is high.

Reset
REQ-022 While rst_n=0 the block SHALL hold state=IDLE, window all zero, w_idx=0, w_valid=0, busy=0 and w_data=0.
REQ-023 Reset asserted mid-block SHALL discard the block immediately.
REQ-024 After rst_n deasserts, blk_ready SHALL be 1 on the first clock.

Verification
REQ-025 ALG=256, "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1:
- W0..W15 equal the input words;
- W16 = 0x61626380 and W17 = 0x000F0000;
- 64 words are produced, with w_last only at idx 63.
REQ-026 ALG=512, "abc" block (W0=0x6162638000000000, W15=0x18):
- W16 = 0x6162638000000000 and W17 = 0x00030000000000C0;
- 80 words are produced, with w_last only at idx 79.
REQ-027 Backpressure: toggle w_ready randomly during a block. Required: the output word sequence is identical to the w_ready=1 run, and w_data/w_idx are stable during every stall.
REQ-028 Back-to-back: blk_valid is held high with two blocks. Required: the idx 63 word of block A is followed on the very next cycle by idx 0 of block B, with no gap.
REQ-029 Abort at idx 20 with blk_valid=1 in the same cycle. Required: next cycle IDLE, w_valid=0, block not accepted, blk_ready=1.
REQ-030 rst_n pulsed low at idx 30. Required: outputs go to zero asynchronously; a new block afterwards starts at idx 0 with correct W16.
